// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
// Pure declarations, no logic and no latency.
// No handshaking involved.
package period_meter_pkg;

  // Meter state: waiting for an arming edge, or timing a period.
  typedef enum logic {
    S_IDLE,
    S_MEASURE
  } meter_state_t;

  // Fewer than two flops cannot resolve metastability on an async input.
  localparam int unsigned MIN_SYNC_STAGES = 2;

  // Saturation limit of a width-bit counter, (1<<width)-1.
  // A 32-bit shift wraps to zero, so width 32 still yields all ones.
  function automatic logic [31:0] cnt_limit(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an async level into clk_i and flags its rising/falling edges.
// Edge flags are combinational, valid in the cycle after SYNC_STAGES-1 edges.
// No backpressure: a free-running sampler.
module sync_edge
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);

  // Clamp so a careless override cannot drop below a safe chain depth.
  localparam int STAGES = (SYNC_STAGES < int'(MIN_SYNC_STAGES)) ?
                          int'(MIN_SYNC_STAGES) : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  // Remember the previous synchronized sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow async square wave in clk_i cycles.
// Results register one edge after the synchronized rise (SYNC_STAGES edges after sampling).
// No backpressure: valid_o is a one-cycle strobe, results hold until the next one.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_limit(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Seeing this count with no rise means the next edge saturates the counter.
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

  logic rise;
  logic fall;
  logic level_unused;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcap;

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] period_d, high_d;
  logic             valid_d, locked_d, timeout_d;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (sig_i),
    .rise_o  (rise),
    .fall_o  (fall),
    .level_o (level_unused)
  );

  // Cycles since the last rise; restarts at 1 so a rise reads the full period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Snapshot the count at the falling edge: that is the high time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcap <= '0;
    end else if (fall) begin
      hcap <= cnt;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next output values; results hold unless a rise completes a period.
  always_comb begin
    state_d   = state_q;
    period_d  = period_o;
    high_d    = high_o;
    valid_d   = 1'b0;
    locked_d  = locked_o;
    timeout_d = timeout_o;
    case (state_q)
      S_IDLE: begin
        // First rise only arms; there is no reference edge yet.
        if (rise) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          period_d  = cnt;
          // Rise and fall are exclusive after synchronization; guard anyway.
          high_d    = fall ? cnt : hcap;
          valid_d   = 1'b1;
          locked_d  = 1'b1;
          timeout_d = 1'b0;
        end else if (cnt >= CNT_NEAR) begin
          // Counter saturates on this edge: signal lost (stuck high or low).
          state_d   = S_IDLE;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_o  <= '0;
      high_o    <= '0;
      valid_o   <= 1'b0;
      locked_o  <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      period_o  <= period_d;
      high_o    <= high_d;
      valid_o   <= valid_d;
      locked_o  <= locked_d;
      timeout_o <= timeout_d;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int CNT_W = 8;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig   = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             valid;
  logic             locked;
  logic             timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit is_to;
    int period;
    int high;
    int at;
  } ev_t;

  ev_t exp_q[$];

  period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sig_i     (sig),
    .period_o  (period),
    .high_o    (high),
    .valid_o   (valid),
    .locked_o  (locked),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: works on sampled waveform edges only. A rise sampled
  // at edge t reports at edge t+2; the gap to the previous rise is the
  // period, the gap to the intervening fall is the high time. A gap of
  // MAX or more without a rise is loss of signal, reported at last+MAX+1.
  bit in_meas   = 1'b0;
  bit prev_s    = 1'b0;
  int last_rise = 0;
  int last_fall = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      in_meas = 1'b0;
      prev_s  = 1'b0;
      exp_q.delete();
    end else begin
      if (in_meas && (cyc - last_rise) >= MAX) begin
        exp_q.push_back('{1'b1, 0, 0, last_rise + MAX + 1});
        in_meas = 1'b0;
      end
      if (sig && !prev_s) begin
        if (in_meas)
          exp_q.push_back('{1'b0, cyc - last_rise, last_fall - last_rise, cyc + 2});
        in_meas   = 1'b1;
        last_rise = cyc;
      end
      if (!sig && prev_s)
        last_fall = cyc;
      prev_s = sig;
    end
  end

  // Monitor: pops expected events as the DUT presents them.
  bit  prev_to = 1'b0;
  int  last_p  = 0;
  int  last_h  = 0;
  ev_t ev;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", int'({period, high, valid, locked, timeout}), 0);
      prev_to = 1'b0;
      last_p  = 0;
      last_h  = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        ev = exp_q.pop_front();
        check(ev.is_to ? "missing_timeout" : "missing_valid", 0, 1);
      end
      if (valid) begin
        if (exp_q.size() > 0 && !exp_q[0].is_to && exp_q[0].at == cyc) begin
          ev = exp_q.pop_front();
          check("period", int'(period), ev.period);
          check("high", int'(high), ev.high);
          check("locked_on_valid", int'(locked), 1);
          check("timeout_on_valid", int'(timeout), 0);
          last_p = ev.period;
          last_h = ev.high;
        end else begin
          check("unexpected_valid", 1, 0);
        end
      end
      if (timeout && !prev_to) begin
        if (exp_q.size() > 0 && exp_q[0].is_to && exp_q[0].at == cyc) begin
          void'(exp_q.pop_front());
          check("locked_on_timeout", int'(locked), 0);
          check("period_hold", int'(period), last_p);
          check("high_hold", int'(high), last_h);
        end else begin
          check("unexpected_timeout", 1, 0);
        end
      end
      if (prev_to && !timeout && !valid)
        check("timeout_cleared_without_valid", 0, 1);
      prev_to = timeout;
    end
  end

  // One waveform segment, entered and left on a falling clock edge.
  task automatic seg(input logic lvl, input int n);
    sig = lvl;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned p;
    int unsigned h;
    rst_n = 1'b0;
    sig   = 1'b0;
    @(negedge clk);
    // Input toggles while held in reset: nothing may come out.
    for (int i = 0; i < 10; i++) begin
      sig = ~sig;
      @(negedge clk);
    end
    sig   = 1'b0;
    rst_n = 1'b1;

    // Divide-by-64: low 32, high 32.
    repeat (5) begin
      seg(1'b0, 32);
      seg(1'b1, 32);
    end
    seg(1'b0, 32);

    // Rate change to period 10, high 3.
    repeat (4) begin
      seg(1'b1, 3);
      seg(1'b0, 7);
    end

    // Toggle every cycle: minimum period 2, high 1.
    repeat (6) begin
      seg(1'b1, 1);
      seg(1'b0, 1);
    end

    // Random periods and duty cycles.
    repeat (25) begin
      p = $urandom_range(150, 2);
      h = $urandom_range(p - 1, 1);
      seg(1'b1, int'(h));
      seg(1'b0, int'(p - h));
    end

    // Stuck low after a rise, then resume.
    seg(1'b1, 4);
    seg(1'b0, 300);
    repeat (4) begin
      seg(1'b1, 6);
      seg(1'b0, 9);
    end

    // Stuck high, then resume.
    seg(1'b1, 300);
    seg(1'b0, 10);
    repeat (4) begin
      seg(1'b1, 6);
      seg(1'b0, 9);
    end

    // Longest period that still measures, then one that times out.
    seg(1'b1, 100);
    seg(1'b0, 154);
    seg(1'b1, 100);
    seg(1'b0, 155);
    repeat (3) begin
      seg(1'b1, 5);
      seg(1'b0, 5);
    end

    // Asynchronous reset in the middle of a high phase.
    repeat (3) begin
      seg(1'b1, 8);
      seg(1'b0, 8);
    end
    seg(1'b1, 4);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", int'({period, high, valid, locked, timeout}), 0);
    @(negedge clk);
    seg(1'b1, 3);
    rst_n = 1'b1;
    repeat (5) begin
      seg(1'b1, 7);
      seg(1'b0, 13);
    end
    seg(1'b0, 10);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
